// File: rtl/quadrature_counter_if.sv
// Encoder pins, control strobes and position/status outputs of quadrature_counter.
// The index pin and its modport entries exist only when QUAD_INDEX_EN is defined.
interface quadrature_counter_if #(parameter int WIDTH = 16);
  logic                    quadA;
  logic                    quadB;
  logic                    clear;
  logic                    load;
  logic [WIDTH-1:0]        load_value;
  logic                    error_clr;
  logic signed [WIDTH-1:0] count;
  logic                    dir;
  logic                    step;
  logic                    error;
`ifdef QUAD_INDEX_EN
  logic                    index;

  modport master (
    output quadA, quadB, index, clear, load, load_value, error_clr,
    input  count, dir, step, error
  );
  modport slave (
    input  quadA, quadB, index, clear, load, load_value, error_clr,
    output count, dir, step, error
  );
`else
  modport master (
    output quadA, quadB, clear, load, load_value, error_clr,
    input  count, dir, step, error
  );
  modport slave (
    input  quadA, quadB, clear, load, load_value, error_clr,
    output count, dir, step, error
  );
`endif
endinterface

// File: rtl/quadrature_counter.sv
// Quadrature decoder: sync + glitch filter + 4x Gray decode into a signed position; QUAD_INDEX_EN adds index zeroing.
// Latency raw edge -> count/step is SYNC_STAGES+FILTER_LEN+1 clocks; no backpressure, every accepted step is applied.
module quadrature_counter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int SATURATE    = 0
) (
  input  logic               clk,
  input  logic               reset,
  quadrature_counter_if.slave bus
);

`ifdef QUAD_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic signed [WIDTH-1:0] CNT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] CNT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  logic [NCH-1:0]                  raw;
  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0]                  synced;
  logic [NCH-1:0]                  filt;
  logic [CW-1:0]                   flt_cnt [NCH];
  logic [1:0]                      cur;
  logic [1:0]                      prev_q;
  state_t                          state_q, state_d;
  logic                            mv_up, mv_dn, mv_bad;
  logic                            idx_hit;
  logic signed [WIDTH-1:0]         count_q, cnt_stepped;
  logic                            dir_q, step_q, error_q;

`ifdef QUAD_INDEX_EN
  logic idx_q;

  assign raw     = {bus.index, bus.quadA, bus.quadB};
  assign idx_hit = filt[2] & ~idx_q & (cur == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) idx_q <= 1'b0;
    else       idx_q <= filt[2];
  end
`else
  assign raw     = {bus.quadA, bus.quadB};
  assign idx_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end
  assign synced = sync_q[SYNC_STAGES-1];

  // A channel only moves once the synced level has disagreed with it FILTER_LEN samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= '0;
      for (int c = 0; c < NCH; c++) flt_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (synced[c] == filt[c]) begin
          flt_cnt[c] <= '0;
        end else if (flt_cnt[c] == CW'(FILTER_LEN - 1)) begin
          filt[c]    <= synced[c];
          flt_cnt[c] <= '0;
        end else begin
          flt_cnt[c] <= flt_cnt[c] + CW'(1);
        end
      end
    end
  end
  assign cur = filt[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      prev_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      prev_q  <= cur;
    end
  end

  // {A,B} walks 00->10->11->01->00 when moving up.
  always_comb begin
    state_d = state_q;
    mv_up   = 1'b0;
    mv_dn   = 1'b0;
    mv_bad  = 1'b0;
    case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (cur != prev_q) begin
          case ({prev_q, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: mv_up  = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: mv_dn  = 1'b1;
            default:                                mv_bad = 1'b1;
          endcase
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    cnt_stepped = count_q;
    if (mv_up) begin
      if (SATURATE != 0 && count_q == CNT_MAX) cnt_stepped = count_q;
      else                                     cnt_stepped = count_q + WIDTH'(1);
    end else if (mv_dn) begin
      if (SATURATE != 0 && count_q == CNT_MIN) cnt_stepped = count_q;
      else                                     cnt_stepped = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (bus.clear)            count_q <= '0;
      else if (idx_hit)         count_q <= '0;
      else if (bus.load)        count_q <= $signed(bus.load_value);
      else if (mv_up || mv_dn)  count_q <= cnt_stepped;

      if (mv_up || mv_dn) dir_q <= mv_up;
      step_q <= mv_up | mv_dn;

      if (mv_bad)             error_q <= 1'b1;
      else if (bus.error_clr) error_q <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.error = error_q;

endmodule

// File: tb/tb_quadrature_counter.sv
// Drives a wrapping and a saturating quadrature_counter with identical stimulus and
// compares both against a Gray-position reference model every cycle.
module tb_quadrature_counter;
  localparam int W = 16;
  localparam int S = 2;
  localparam int F = 4;
  localparam int L = S + F + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quadrature_counter_if #(.WIDTH(W)) bus0 ();
  quadrature_counter_if #(.WIDTH(W)) bus1 ();

  assign bus1.quadA      = bus0.quadA;
  assign bus1.quadB      = bus0.quadB;
  assign bus1.clear      = bus0.clear;
  assign bus1.load       = bus0.load;
  assign bus1.load_value = bus0.load_value;
  assign bus1.error_clr  = bus0.error_clr;
`ifdef QUAD_INDEX_EN
  assign bus1.index      = bus0.index;
`endif

  quadrature_counter #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_LEN(F), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .bus(bus0));
  quadrature_counter #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_LEN(F), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .bus(bus1));

  int   total = 0;
  int   bad   = 0;
  int   exp_w, exp_s, pos;
  bit   exp_dir, exp_err, exp_step;
  logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  function automatic int wrapv(input int v);
    if (v > 32767)  return v - 65536;
    if (v < -32768) return v + 65536;
    return v;
  endfunction

  function automatic int satv(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [31:0] b16(input int v);
    logic [31:0] t;
    t = v;
    return {16'h0, t[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input bit full);
    chk("cnt_wrap",  {16'h0, bus0.count}, b16(exp_w));
    chk("cnt_sat",   {16'h0, bus1.count}, b16(exp_s));
    chk("step_wrap", 32'(bus0.step), 32'(exp_step));
    chk("step_sat",  32'(bus1.step), 32'(exp_step));
    if (full) begin
      chk("dir_wrap", 32'(bus0.dir),   32'(exp_dir));
      chk("dir_sat",  32'(bus1.dir),   32'(exp_dir));
      chk("err_wrap", 32'(bus0.error), 32'(exp_err));
      chk("err_sat",  32'(bus1.error), 32'(exp_err));
    end
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      exp_step = 0;
      observe(0);
    end
  endtask

  // side: 0 none, 1 load lv, 2 clear, 3 error_clr -- asserted so it lands on the same edge as the step.
  task automatic move(input logic [1:0] nab, input int hold, input int side, input logic [15:0] lv);
    int ni, d;
    ni = 0;
    for (int i = 0; i < 4; i++) if (gray[i] == nab) ni = i;
    d = (ni - pos + 4) % 4;
    bus0.quadA = nab[1];
    bus0.quadB = nab[0];
    for (int k = 1; k <= hold; k++) begin
      tick();
      bus0.clear = 0; bus0.load = 0; bus0.error_clr = 0;
      exp_step = 0;
      if (k == L) begin
        if (d == 2) exp_err = 1;
        else begin
          if (d != 0) begin
            exp_step = 1;
            exp_dir  = (d == 1);
          end
          if (side == 3) exp_err = 0;
        end
        if (side == 2) begin
          exp_w = 0; exp_s = 0;
        end else if (side == 1) begin
          exp_w = int'($signed(lv)); exp_s = exp_w;
        end else if (d == 1 || d == 3) begin
          exp_w = wrapv(exp_w + ((d == 1) ? 1 : -1));
          exp_s = satv(exp_s + ((d == 1) ? 1 : -1));
        end
      end
      observe(k == L);
      if (k == L - 1) begin
        case (side)
          1: begin bus0.load = 1; bus0.load_value = lv; end
          2: bus0.clear = 1;
          3: bus0.error_clr = 1;
          default: ;
        endcase
      end
    end
    pos = ni;
  endtask

  task automatic glitch(input int len);
    bus0.quadA = ~bus0.quadA;
    for (int k = 1; k <= len + L + 2; k++) begin
      tick();
      if (k == len) bus0.quadA = ~bus0.quadA;
      exp_step = 0;
      observe(0);
    end
  endtask

  task automatic ctrl(input bit c, input bit l, input bit e, input logic [15:0] lv);
    bus0.clear = c; bus0.load = l; bus0.error_clr = e; bus0.load_value = lv;
    tick();
    bus0.clear = 0; bus0.load = 0; bus0.error_clr = 0;
    exp_step = 0;
    if (c) begin
      exp_w = 0; exp_s = 0;
    end else if (l) begin
      exp_w = int'($signed(lv)); exp_s = exp_w;
    end
    if (e) exp_err = 0;
    observe(1);
  endtask

  task automatic hard_reset();
    reset = 1;
    tick();
    reset = 0;
    exp_w = 0; exp_s = 0; exp_dir = 0; exp_err = 0; exp_step = 0;
    observe(1);
    settle(L + 2);
  endtask

  initial begin
    int r, hold, side;
    logic [15:0] lv;
    reset = 1;
    bus0.quadA = 0; bus0.quadB = 0; bus0.clear = 0; bus0.load = 0;
    bus0.load_value = '0; bus0.error_clr = 0;
`ifdef QUAD_INDEX_EN
    bus0.index = 0;
`endif
    exp_w = 0; exp_s = 0; exp_dir = 0; exp_err = 0; exp_step = 0; pos = 0;
    tick();
    tick();
    observe(1);
    reset = 0;
    settle(L + 2);

    for (int i = 1; i <= 4; i++) move(gray[i % 4], 10, 0, 16'h0);
    ctrl(1, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) move(gray[(pos + 3) % 4], 10, 0, 16'h0);
    hard_reset();

    for (int i = 0; i < 3; i++) glitch(F - 1);

    move(gray[(pos + 2) % 4], L + 2, 0, 16'h0);
    ctrl(0, 0, 1, 16'h0);
    move(gray[(pos + 2) % 4], L + 2, 3, 16'h0);
    ctrl(0, 0, 1, 16'h0);

    ctrl(0, 1, 0, 16'h7FFF);
    move(gray[(pos + 1) % 4], L + 2, 0, 16'h0);
    ctrl(0, 1, 0, 16'h8000);
    move(gray[(pos + 3) % 4], L + 2, 0, 16'h0);

    ctrl(1, 1, 0, 16'h1234);
    move(gray[(pos + 1) % 4], L + 2, 1, 16'h0055);
    move(gray[(pos + 1) % 4], L + 2, 2, 16'h0);

`ifdef QUAD_INDEX_EN
    while (pos != 2) move(gray[(pos + 1) % 4], L + 2, 0, 16'h0);
    ctrl(0, 1, 0, 16'h0042);
    bus0.index = 1;
    for (int k = 1; k <= L + 2; k++) begin
      tick();
      exp_step = 0;
      if (k == L) begin
        exp_w = 0; exp_s = 0;
      end
      observe(0);
    end
    bus0.index = 0;
    settle(L + 2);
    ctrl(0, 1, 0, 16'h0042);
    move(gray[1], L + 2, 0, 16'h0);
    bus0.index = 1;
    settle(L + 2);
    bus0.index = 0;
    settle(L + 2);
`endif

    repeat (60) begin
      r    = $urandom_range(0, 9);
      hold = L + 1 + $urandom_range(0, 3);
      side = $urandom_range(0, 7);
      if (side > 3) side = 0;
      lv   = 16'($urandom);
      if (r <= 3)      move(gray[(pos + 1) % 4], hold, side, lv);
      else if (r <= 6) move(gray[(pos + 3) % 4], hold, side, lv);
      else if (r == 7) move(gray[(pos + 2) % 4], hold, side, lv);
      else if (r == 8) move(gray[pos], hold, side, lv);
      else             glitch(F - 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
